cmos_capture_pack: RTL

CMOS_CAPTURE_PACK -- requirements
Module: cmos_capture_pack

---
 rtl/cmos_capture_pack.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/cmos_capture_pack.sv
// DVP sensor capture: skips settling frames, optionally packs byte pairs into pixels, measures fps.
// Define CMOS_CAPTURE_STATS_EN to build the frame_lines / line_pixels statistics counters.
module cmos_capture_pack #(
    parameter int DATA_W      = 8,
    parameter int PACK_MODE   = 0,
    parameter int WAIT_FRAMES = 10,
    parameter int PCLK_HZ     = 24_000_000,
    parameter int FPS_WIN_S   = 2
) (
    input  logic                cmos_pclk,
    input  logic                rst_n,
    input  logic                cmos_vsync,
    input  logic                cmos_href,
    input  logic [DATA_W-1:0]   cmos_data,
    output logic                out_vsync,
    output logic                out_href,
    output logic                out_valid,
    output logic [2*DATA_W-1:0] out_data,
    output logic                sync_done,
    output logic [7:0]          fps_rate,
    output logic [11:0]         frame_lines,
    output logic [11:0]         line_pixels
);
    // state | meaning
    // WAIT  | counting settling frames after reset
    // ARM   | settled, waiting for the next frame boundary
    // RUN   | passing frames through, held until reset
    typedef enum logic [1:0] {ST_WAIT, ST_ARM, ST_RUN} state_t;

    localparam int WIN_LEN = PCLK_HZ * FPS_WIN_S;
    localparam int WIN_W   = $clog2(WIN_LEN);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);

    state_t              state;
    logic [3:0]          wait_cnt;
    logic                vsync_r0, vsync_r1, href_r0, href_r1;
    logic [DATA_W-1:0]   data_r0, data_r1;
    logic                vsync_end, run;
    logic [WIN_W-1:0]    win_cnt;
    logic [8:0]          fps_frames, fps_div;

    assign vsync_end = vsync_r1 & ~vsync_r0;
    assign run       = (state == ST_RUN);
    assign fps_div   = fps_frames / 9'(FPS_WIN_S);

    always_ff @(posedge cmos_pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_r0 <= 1'b0;
            vsync_r1 <= 1'b0;
            href_r0  <= 1'b0;
            href_r1  <= 1'b0;
            data_r0  <= '0;
            data_r1  <= '0;
        end else begin
            vsync_r0 <= cmos_vsync;
            vsync_r1 <= vsync_r0;
            href_r0  <= cmos_href;
            href_r1  <= href_r0;
            data_r0  <= cmos_data;
            data_r1  <= data_r0;
        end
    end

    always_ff @(posedge cmos_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_WAIT;
            wait_cnt  <= 4'd0;
            sync_done <= 1'b0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (wait_cnt == 4'(WAIT_FRAMES))
                        state <= ST_ARM;
                    else if (vsync_end)
                        wait_cnt <= wait_cnt + 4'd1;
                end
                // RUN starts just after a vsync falling edge, so the first frame out is whole
                ST_ARM: begin
                    if (vsync_end) begin
                        state     <= ST_RUN;
                        sync_done <= 1'b1;
                    end
                end
                ST_RUN:  state <= ST_RUN;
                default: state <= ST_WAIT;
            endcase
        end
    end

    // Frame-rate meter runs regardless of capture state
    always_ff @(posedge cmos_pclk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt    <= '0;
            fps_frames <= 9'd0;
            fps_rate   <= 8'd0;
        end else if (win_cnt == WIN_LAST) begin
            win_cnt    <= '0;
            fps_rate   <= (fps_div > 9'd255) ? 8'd255 : fps_div[7:0];
            fps_frames <= vsync_end ? 9'd1 : 9'd0;
        end else begin
            win_cnt <= win_cnt + WIN_W'(1);
            if (vsync_end && fps_frames != 9'd511)
                fps_frames <= fps_frames + 9'd1;
        end
    end

    generate
        if (PACK_MODE == 0) begin : g_raw
            assign out_vsync = run & vsync_r1;
            assign out_href  = run & href_r1;
            assign out_valid = run & href_r1;
            assign out_data  = run ? {{DATA_W{1'b0}}, data_r1} : '0;
        end else begin : g_pack
            logic              phase;
            logic [DATA_W-1:0] byte_hold;

            // phase is forced to 0 while href is low, so every line starts on phase 0
            // and a trailing odd byte is simply dropped
            always_ff @(posedge cmos_pclk or negedge rst_n) begin
                if (!rst_n) begin
                    phase     <= 1'b0;
                    byte_hold <= '0;
                    out_vsync <= 1'b0;
                    out_href  <= 1'b0;
                    out_valid <= 1'b0;
                    out_data  <= '0;
                end else begin
                    phase     <= href_r1 ? ~phase : 1'b0;
                    if (href_r1 && !phase)
                        byte_hold <= data_r1;
                    out_vsync <= run & vsync_r1;
                    out_href  <= run & href_r1;
                    out_valid <= run & href_r1 & phase;
                    if (!run)
                        out_data <= '0;
                    else if (href_r1 && phase)
                        out_data <= {byte_hold, data_r1};
                end
            end
        end
    endgenerate

`ifdef CMOS_CAPTURE_STATS_EN
    logic        href_r2;
    logic [11:0] line_cnt, pix_cnt, pix_total;

    // In pack mode the last pixel's out_valid lands on the href falling-edge cycle
    assign pix_total = (out_valid && pix_cnt != 12'hFFF) ? pix_cnt + 12'd1 : pix_cnt;

    always_ff @(posedge cmos_pclk or negedge rst_n) begin
        if (!rst_n) begin
            href_r2     <= 1'b0;
            line_cnt    <= 12'd0;
            pix_cnt     <= 12'd0;
            frame_lines <= 12'd0;
            line_pixels <= 12'd0;
        end else begin
            href_r2 <= href_r1;
            if (!run) begin
                line_cnt <= 12'd0;
                pix_cnt  <= 12'd0;
            end else begin
                if (vsync_end) begin
                    frame_lines <= line_cnt;
                    line_cnt    <= 12'd0;
                end else if (href_r1 && !href_r2 && line_cnt != 12'hFFF) begin
                    line_cnt <= line_cnt + 12'd1;
                end
                if (href_r2 && !href_r1) begin
                    line_pixels <= pix_total;
                    pix_cnt     <= 12'd0;
                end else begin
                    pix_cnt <= pix_total;
                end
            end
        end
    end
`else
    assign frame_lines = 12'd0;
    assign line_pixels = 12'd0;
`endif

endmodule
